// File: rtl/shift_deserializer_8bit_if.sv
// rtl/shift_deserializer_8bit_if.sv - serial input and holding-register handshake bundle
interface shift_deserializer_8bit_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       mod;
  logic             sin;
  logic             sin_vld;
  logic             sof;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             dout_rdy;
  logic             busy;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    output mod, sin, sin_vld, sof, dout_rdy, ovr_clr,
    input  dout, dout_vld, busy, overrun
  );

  modport slave (
    input  mod, sin, sin_vld, sof, dout_rdy, ovr_clr,
    output dout, dout_vld, busy, overrun
  );
endinterface

// File: rtl/shift_deserializer_8bit.sv
// rtl/shift_deserializer_8bit.sv - serial-in/parallel-out receiver with single-entry holding register
module shift_deserializer_8bit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  shift_deserializer_8bit_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         cur_mod_q, cur_mod_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;
  logic               overrun_q, overrun_d;

  logic               take_bit;
  logic               complete;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   cnt_base;
  logic [WIDTH-1:0]   shifted;

  always_comb begin
    state_d    = state_q;
    cur_mod_d  = cur_mod_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    overrun_d  = overrun_q;
    take_bit   = 1'b0;
    complete   = 1'b0;
    mode       = cur_mod_q;
    cnt_base   = cnt_q;
    shifted    = shreg_q;

    if (bus.sof && !bus.sin_vld) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bus.sin_vld) begin
      if (state_q == IDLE || bus.sof) begin
        // A new word starts here; only a real shift mode may start it.
        cnt_base = '0;
        if (bus.mod == 2'b01 || bus.mod == 2'b10) begin
          take_bit  = 1'b1;
          mode      = bus.mod;
          cur_mod_d = bus.mod;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end else begin
        take_bit = 1'b1;
      end
    end

    if (mode == 2'b01) begin
      shifted = {bus.sin, shreg_q[WIDTH-1:1]};
    end else begin
      shifted = {shreg_q[WIDTH-2:0], bus.sin};
    end

    if (take_bit) begin
      shreg_d = shifted;
      if (cnt_base == CNT_W'(WIDTH - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end else begin
        cnt_d   = cnt_base + CNT_W'(1);
        state_d = SHIFT;
      end
    end

    // A completion in the same cycle as an accept refills the register seamlessly.
    if (complete) begin
      if (!dout_vld_q || bus.dout_rdy) begin
        dout_d     = shifted;
        dout_vld_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dout_vld_q && bus.dout_rdy) begin
      dout_vld_d = 1'b0;
    end

    if (!(complete && dout_vld_q && !bus.dout_rdy) && bus.ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_mod_q  <= 2'b00;
      shreg_q    <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_mod_q  <= cur_mod_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.busy     = (state_q == SHIFT);
  assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_shift_deserializer_8bit.sv
// tb/tb_shift_deserializer_8bit.sv - directed and randomized checks of shift_deserializer_8bit
module tb_shift_deserializer_8bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  shift_deserializer_8bit_if #(.WIDTH(8)) bus ();

  shift_deserializer_8bit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.sin_vld = 1'b0;
    bus.sof     = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Sends bits first..first+n-1 of word w in the wire order implied by m.
  task automatic send_bits(input logic [1:0] m, input logic [7:0] w,
                           input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      bus.mod     = m;
      bus.sin     = (m == 2'b10) ? w[7-k] : w[k];
      bus.sin_vld = 1'b1;
      tick();
    end
    bus.sin_vld = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.dout !== 8'h00 || bus.dout_vld !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset: dout=%h vld=%b busy=%b ovr=%b required all 0",
               bus.dout, bus.dout_vld, bus.busy, bus.overrun);
    end
  endtask

  task automatic test_lsb();
    bus.dout_rdy = 1'b1;
    send_bits(2'b01, 8'h1E, 0, 7);
    total++;
    if (bus.busy !== 1'b1 || bus.dout_vld !== 1'b0) begin
      bad++;
      $display("FAIL lsb_partial: busy=%b vld=%b required busy=1 vld=0", bus.busy, bus.dout_vld);
    end
    send_bits(2'b01, 8'h1E, 7, 1);
    total++;
    if (bus.dout !== 8'h1E || bus.dout_vld !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL lsb_word: dout=%h vld=%b busy=%b required 1e 1 0", bus.dout, bus.dout_vld, bus.busy);
    end
  endtask

  task automatic test_msb();
    bus.dout_rdy = 1'b1;
    // Same wire bits 0,1,1,1,1,0,0,0 as the LSB-first case.
    send_bits(2'b10, 8'h78, 0, 8);
    total++;
    if (bus.dout !== 8'h78 || bus.dout_vld !== 1'b1) begin
      bad++;
      $display("FAIL msb_word: dout=%h vld=%b required 78 1", bus.dout, bus.dout_vld);
    end
    idle(1);
    total++;
    if (bus.dout_vld !== 1'b0 || bus.dout !== 8'h78) begin
      bad++;
      $display("FAIL accept: dout=%h vld=%b required 78 0", bus.dout, bus.dout_vld);
    end
  endtask

  task automatic test_overrun();
    bus.dout_rdy = 1'b0;
    send_bits(2'b01, 8'h11, 0, 8);
    total++;
    if (bus.dout !== 8'h11 || bus.dout_vld !== 1'b1 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_first: dout=%h vld=%b ovr=%b required 11 1 0", bus.dout, bus.dout_vld, bus.overrun);
    end
    send_bits(2'b01, 8'h22, 0, 8);
    total++;
    if (bus.dout !== 8'h11 || bus.dout_vld !== 1'b1 || bus.overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_second: dout=%h vld=%b ovr=%b required 11 1 1", bus.dout, bus.dout_vld, bus.overrun);
    end
    idle(2);
    total++;
    if (bus.overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky: ovr=%b required 1", bus.overrun);
    end
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    total++;
    if (bus.overrun !== 1'b0 || bus.dout !== 8'h11) begin
      bad++;
      $display("FAIL ovr_clear: ovr=%b dout=%h required 0 11", bus.overrun, bus.dout);
    end
  endtask

  task automatic test_accept_same_cycle();
    bus.dout_rdy = 1'b0;
    send_bits(2'b01, 8'h22, 0, 7);
    bus.dout_rdy = 1'b1;
    send_bits(2'b01, 8'h22, 7, 1);
    total++;
    if (bus.dout !== 8'h22 || bus.dout_vld !== 1'b1 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle: dout=%h vld=%b ovr=%b required 22 1 0", bus.dout, bus.dout_vld, bus.overrun);
    end
    // Overrun set must win over a simultaneous clear.
    bus.dout_rdy = 1'b0;
    send_bits(2'b01, 8'h33, 0, 7);
    bus.ovr_clr = 1'b1;
    send_bits(2'b01, 8'h33, 7, 1);
    bus.ovr_clr = 1'b0;
    total++;
    if (bus.overrun !== 1'b1 || bus.dout !== 8'h22) begin
      bad++;
      $display("FAIL set_over_clr: ovr=%b dout=%h required 1 22", bus.overrun, bus.dout);
    end
    bus.ovr_clr  = 1'b1;
    bus.dout_rdy = 1'b1;
    idle(1);
    bus.ovr_clr  = 1'b0;
  endtask

  task automatic test_sof();
    int words = 0;
    bus.dout_rdy = 1'b1;
    send_bits(2'b10, 8'hFF, 0, 3);
    bus.mod     = 2'b01;
    bus.sin     = 1'b1;
    bus.sin_vld = 1'b1;
    bus.sof     = 1'b1;
    tick();
    bus.sof = 1'b0;
    if (bus.dout_vld === 1'b1) words++;
    for (int k = 1; k < 8; k++) begin
      send_bits(2'b01, 8'hA5, k, 1);
      if (bus.dout_vld === 1'b1) words++;
      if (k == 7) begin
        total++;
        if (bus.dout !== 8'hA5 || bus.dout_vld !== 1'b1) begin
          bad++;
          $display("FAIL sof_word: dout=%h vld=%b required a5 1", bus.dout, bus.dout_vld);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (bus.dout_vld === 1'b1) words++;
    end
    total++;
    if (words != 1) begin
      bad++;
      $display("FAIL sof_count: words=%0d required 1", words);
    end
    // sof without a bit just aborts the partial word.
    send_bits(2'b01, 8'h00, 0, 4);
    bus.sof = 1'b1;
    tick();
    bus.sof = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.dout !== 8'hA5) begin
      bad++;
      $display("FAIL sof_abort: busy=%b dout=%h required 0 a5", bus.busy, bus.dout);
    end
  endtask

  task automatic test_reset_midword();
    bus.dout_rdy = 1'b0;
    send_bits(2'b01, 8'h5A, 0, 8);
    send_bits(2'b01, 8'h00, 0, 5);
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.dout !== 8'h00 || bus.dout_vld !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: dout=%h vld=%b busy=%b ovr=%b required all 0",
               bus.dout, bus.dout_vld, bus.busy, bus.overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    send_bits(2'b01, 8'h3C, 0, 8);
    total++;
    if (bus.dout !== 8'h3C || bus.dout_vld !== 1'b1) begin
      bad++;
      $display("FAIL rst_fresh: dout=%h vld=%b required 3c 1", bus.dout, bus.dout_vld);
    end
  endtask

  // Reference: bits are placed directly at their word position; no shift register.
  task automatic test_random();
    int         m_cnt = 0;
    int         m_mode = 1;
    logic [7:0] m_acc = '0;
    logic [7:0] m_dout = '0;
    logic       m_vld = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] word;
    logic       take, done, set;
    int         pos;
    rst = 1'b1;
    #3;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.mod      = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
      bus.sin      = 1'($urandom);
      bus.sin_vld  = ($urandom_range(0, 3) != 0);
      bus.sof      = ($urandom_range(0, 19) == 0);
      bus.dout_rdy = ($urandom_range(0, 2) == 0);
      bus.ovr_clr  = ($urandom_range(0, 14) == 0);
      take = 1'b0;
      done = 1'b0;
      word = '0;
      if (bus.sof && !bus.sin_vld) begin
        m_cnt = 0;
      end else if (bus.sin_vld) begin
        if (m_cnt == 0 || bus.sof) begin
          m_cnt = 0;
          m_acc = '0;
          if (bus.mod == 2'b01 || bus.mod == 2'b10) begin
            m_mode = int'(bus.mod);
            take   = 1'b1;
          end
        end else begin
          take = 1'b1;
        end
      end
      if (take) begin
        pos   = (m_mode == 1) ? m_cnt : 7 - m_cnt;
        m_acc = m_acc | (8'(bus.sin) << pos);
        m_cnt = m_cnt + 1;
        if (m_cnt == 8) begin
          done  = 1'b1;
          word  = m_acc;
          m_cnt = 0;
        end
      end
      set = done && m_vld && !bus.dout_rdy;
      if (done && !set) begin
        m_dout = word;
        m_vld  = 1'b1;
      end else if (!done && m_vld && bus.dout_rdy) begin
        m_vld = 1'b0;
      end
      if (set) m_ovr = 1'b1;
      else if (bus.ovr_clr) m_ovr = 1'b0;
      tick();
      total++;
      if (bus.dout !== m_dout || bus.dout_vld !== m_vld || bus.busy !== (m_cnt != 0) || bus.overrun !== m_ovr) begin
        bad++;
        $display("FAIL random[%0d]: dout=%h vld=%b busy=%b ovr=%b required %h %b %b %b",
                 cyc, bus.dout, bus.dout_vld, bus.busy, bus.overrun, m_dout, m_vld, (m_cnt != 0), m_ovr);
      end
    end
  endtask

  initial begin
    bus.mod      = 2'b00;
    bus.sin      = 1'b0;
    bus.sin_vld  = 1'b0;
    bus.sof      = 1'b0;
    bus.dout_rdy = 1'b0;
    bus.ovr_clr  = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    // Strobes in hold mode must not start a word.
    bus.mod     = 2'b00;
    bus.sin_vld = 1'b1;
    tick();
    bus.mod = 2'b11;
    tick();
    bus.sin_vld = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_mode: busy=%b required 0", bus.busy);
    end
    test_lsb();
    test_msb();
    test_overrun();
    test_accept_same_cycle();
    test_sof();
    test_reset_midword();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
